// File: rtl/us_cmd_dispatcher.sv
// Upstream command dispatcher: pops 128-bit command FIFO entries and turns them
// into TX-engine completion requests or MWr32 bursts split on payload/4 KB limits.
module us_cmd_dispatcher #(
  parameter int MAX_PAYLOAD_BYTES = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          us_cmd_fifo_empty_i,
  input  logic [127:0]  us_cmd_fifo_dout_i,
  output logic          us_cmd_fifo_rd_en_o,
  output logic          cpl_req_o,
  output logic          cpl_with_data_o,
  output logic [54:0]   cpl_info_o,
  input  logic          cpl_ack_i,
  output logic          mwr_req_o,
  output logic [31:0]   mwr_addr_o,
  output logic [9:0]    mwr_len_dw_o,
  input  logic          mwr_ack_i,
  output logic          up_wr_cmd_compl_o,
  output logic [1:0]    cmd_id_o,
  output logic          invalid_cmd_o,
  output logic          busy_o
);

  localparam logic [1:0]  US_CMD_INVALID   = 2'd0;
  localparam logic [1:0]  US_CMD_CPL_TYPE  = 2'd1;
  localparam logic [1:0]  US_CMD_CPLD_TYPE = 2'd2;
  localparam logic [1:0]  US_CMD_WR32_TYPE = 2'd3;
  localparam logic [12:0] MAX_B            = 13'(MAX_PAYLOAD_BYTES);

  typedef enum logic [2:0] {IDLE, LOAD, CPL, WR_CALC, WR_REQ, DONE} state_t;

  state_t       state, next_state;
  logic [1:0]   ent_type;
  logic [1:0]   ent_id;
  logic [54:0]  ent_payload;
  logic [31:0]  cur_addr;
  logic [12:0]  remaining;
  logic [12:0]  chunk;

  logic [1:0]   dout_type;
  logic [4:0]   len_clamped;
  logic [12:0]  total_bytes;
  logic [12:0]  page_room;
  logic [12:0]  chunk_calc;
  logic         unused_upper;

  assign dout_type    = us_cmd_fifo_dout_i[63:62];
  assign unused_upper = ^us_cmd_fifo_dout_i[127:64];

  // Burst size is 2^len bytes, clamped to the 4 B .. 4 KB range.
  always_comb begin
    len_clamped = us_cmd_fifo_dout_i[61:57];
    if (len_clamped < 5'd2)
      len_clamped = 5'd2;
    else if (len_clamped > 5'd12)
      len_clamped = 5'd12;
    total_bytes = 13'd1 << len_clamped;
  end

  // A TLP may not exceed the max payload nor cross a 4 KB page boundary.
  always_comb begin
    page_room  = 13'h1000 - {1'b0, cur_addr[11:0]};
    chunk_calc = remaining;
    if (MAX_B < chunk_calc)
      chunk_calc = MAX_B;
    if (page_room < chunk_calc)
      chunk_calc = page_room;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_type     <= US_CMD_INVALID;
      ent_id       <= 2'd0;
      ent_payload  <= '0;
      cur_addr     <= '0;
      remaining    <= '0;
      chunk        <= '0;
      mwr_addr_o   <= '0;
      mwr_len_dw_o <= '0;
    end else begin
      case (state)
        LOAD: begin
          ent_type    <= dout_type;
          ent_id      <= us_cmd_fifo_dout_i[56:55];
          ent_payload <= us_cmd_fifo_dout_i[54:0];
          cur_addr    <= {us_cmd_fifo_dout_i[31:2], 2'b00};
          remaining   <= total_bytes;
        end
        WR_CALC: begin
          chunk        <= chunk_calc;
          mwr_addr_o   <= cur_addr;
          mwr_len_dw_o <= chunk_calc[11:2];
        end
        WR_REQ: begin
          if (mwr_ack_i) begin
            cur_addr  <= cur_addr + {19'd0, chunk};
            remaining <= remaining - chunk;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state          = state;
    us_cmd_fifo_rd_en_o = 1'b0;
    cpl_req_o           = 1'b0;
    cpl_with_data_o     = 1'b0;
    cpl_info_o          = '0;
    mwr_req_o           = 1'b0;
    up_wr_cmd_compl_o   = 1'b0;
    cmd_id_o            = 2'd0;
    invalid_cmd_o       = 1'b0;
    busy_o              = (state != IDLE);
    case (state)
      IDLE: begin
        // Gated by rst_n so no pop strobe leaks out while reset is held.
        if (!us_cmd_fifo_empty_i && rst_n) begin
          us_cmd_fifo_rd_en_o = 1'b1;
          next_state          = LOAD;
        end
      end
      LOAD: begin
        case (dout_type)
          US_CMD_CPL_TYPE, US_CMD_CPLD_TYPE: next_state = CPL;
          US_CMD_WR32_TYPE:                  next_state = WR_CALC;
          default: begin
            invalid_cmd_o = 1'b1;
            next_state    = IDLE;
          end
        endcase
      end
      CPL: begin
        cpl_req_o       = 1'b1;
        cpl_with_data_o = (ent_type == US_CMD_CPLD_TYPE);
        cpl_info_o      = ent_payload;
        if (cpl_ack_i)
          next_state = IDLE;
      end
      WR_CALC: next_state = WR_REQ;
      WR_REQ: begin
        mwr_req_o = 1'b1;
        if (mwr_ack_i)
          next_state = (remaining == chunk) ? DONE : WR_CALC;
      end
      DONE: begin
        up_wr_cmd_compl_o = 1'b1;
        cmd_id_o          = ent_id;
        next_state        = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_us_cmd_dispatcher.sv
// Directed self-checking bench for us_cmd_dispatcher with a simple
// non-FWFT FIFO model feeding the DUT.
module tb_us_cmd_dispatcher;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty;
  logic [127:0]  fifo_dout = '0;
  logic          fifo_rd_en;
  logic          cpl_req, cpl_with_data;
  logic [54:0]   cpl_info;
  logic          cpl_ack = 1'b0;
  logic          mwr_req;
  logic [31:0]   mwr_addr;
  logic [9:0]    mwr_len_dw;
  logic          mwr_ack = 1'b0;
  logic          compl;
  logic [1:0]    cmd_id;
  logic          invalid_cmd;
  logic          busy;

  int checks = 0;
  int passes = 0;

  logic [127:0] fifo_mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;

  int pop_cnt = 0, compl_cnt = 0, invalid_cnt = 0, cplreq_cnt = 0, mwrreq_cnt = 0;
  logic [1:0] last_id = 2'd0;

  always #5 clk = ~clk;

  us_cmd_dispatcher #(.MAX_PAYLOAD_BYTES(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .us_cmd_fifo_empty_i(fifo_empty), .us_cmd_fifo_dout_i(fifo_dout),
    .us_cmd_fifo_rd_en_o(fifo_rd_en),
    .cpl_req_o(cpl_req), .cpl_with_data_o(cpl_with_data), .cpl_info_o(cpl_info),
    .cpl_ack_i(cpl_ack),
    .mwr_req_o(mwr_req), .mwr_addr_o(mwr_addr), .mwr_len_dw_o(mwr_len_dw),
    .mwr_ack_i(mwr_ack),
    .up_wr_cmd_compl_o(compl), .cmd_id_o(cmd_id),
    .invalid_cmd_o(invalid_cmd), .busy_o(busy)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en)  pop_cnt++;
    if (invalid_cmd) invalid_cnt++;
    if (cpl_req)     cplreq_cnt++;
    if (mwr_req)     mwrreq_cnt++;
    if (compl) begin
      compl_cnt++;
      last_id = cmd_id;
    end
  end

  function automatic logic [127:0] mk(input logic [1:0] t, input logic [4:0] len,
                                      input logic [1:0] id, input logic [54:0] pl);
    return {64'hDEAD_BEEF_0BAD_F00D, t, len, id, pl};
  endfunction

  task automatic push(input logic [127:0] e);
    fifo_mem[wr_ptr] = e;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_cpl(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpl_req) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) $display("[TB] FAIL cpl_req_timeout: actual no request, required request within 40 cycles");
    else passes++;
  endtask

  task automatic pulse_cpl_ack;
    cpl_ack = 1'b1;
    @(negedge clk);
    cpl_ack = 1'b0;
  endtask

  task automatic expect_mwr(input logic [31:0] addr, input logic [9:0] len, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mwr_req) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) $display("[TB] FAIL %s_timeout: actual no mwr_req, required request", name);
    else passes++;
    checks++;
    if (mwr_addr !== addr) $display("[TB] FAIL %s_addr: actual %h required %h", name, mwr_addr, addr);
    else passes++;
    checks++;
    if (mwr_len_dw !== len) $display("[TB] FAIL %s_len: actual %0d required %0d", name, mwr_len_dw, len);
    else passes++;
    mwr_ack = 1'b1;
    @(negedge clk);
    mwr_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fifo_rd_en !== 1'b0) $display("[TB] FAIL reset_ctrl: actual busy=%b rd_en=%b required 0/0", busy, fifo_rd_en);
    else passes++;
    checks++;
    if ({cpl_req, mwr_req, compl, invalid_cmd} !== 4'b0) $display("[TB] FAIL reset_strobes: actual %b required 0000", {cpl_req, mwr_req, compl, invalid_cmd});
    else passes++;
    checks++;
    if (mwr_addr !== 32'd0 || mwr_len_dw !== 10'd0 || cpl_info !== 55'd0) $display("[TB] FAIL reset_data: actual addr=%h len=%0d info=%h required zeros", mwr_addr, mwr_len_dw, cpl_info);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpl;
    logic [54:0] pl = {3'd2, 1'b0, 1'b0, 2'b01, 10'd1, 16'h0100, 8'h5A, 8'h0F, 6'h10};
    int p0 = pop_cnt, c0 = compl_cnt;
    bit ok;
    push(mk(2'd1, 5'd0, 2'd0, pl));
    wait_cpl(ok);
    checks++;
    if (cpl_with_data !== 1'b0) $display("[TB] FAIL cpl_with_data: actual %b required 0", cpl_with_data);
    else passes++;
    checks++;
    if (cpl_info !== pl) $display("[TB] FAIL cpl_info: actual %h required %h", cpl_info, pl);
    else passes++;
    checks++;
    if (cpl_info[21:14] !== 8'h5A) $display("[TB] FAIL cpl_tag: actual %h required 5a", cpl_info[21:14]);
    else passes++;
    pulse_cpl_ack;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cpl_req !== 1'b0) $display("[TB] FAIL cpl_idle: actual busy=%b req=%b required 0/0", busy, cpl_req);
    else passes++;
    checks++;
    if (pop_cnt - p0 != 1 || compl_cnt != c0) $display("[TB] FAIL cpl_counts: actual pops=%0d compl=%0d required 1/0", pop_cnt - p0, compl_cnt - c0);
    else passes++;
  endtask

  task automatic test_back_to_back;
    logic [54:0] p1 = 55'h12_3456_789A_BCDE;
    logic [54:0] p2 = 55'h0F_EDCB_A987_6543;
    int p0 = pop_cnt;
    bit ok;
    push(mk(2'd2, 5'd0, 2'd0, p1));
    push(mk(2'd1, 5'd0, 2'd0, p2));
    wait_cpl(ok);
    checks++;
    if (cpl_with_data !== 1'b1 || cpl_info !== p1) $display("[TB] FAIL b2b_first: actual wd=%b info=%h required 1/%h", cpl_with_data, cpl_info, p1);
    else passes++;
    pulse_cpl_ack;
    wait_cpl(ok);
    checks++;
    if (cpl_with_data !== 1'b0 || cpl_info !== p2) $display("[TB] FAIL b2b_second: actual wd=%b info=%h required 0/%h", cpl_with_data, cpl_info, p2);
    else passes++;
    pulse_cpl_ack;
    repeat (2) @(negedge clk);
    checks++;
    if (pop_cnt - p0 != 2) $display("[TB] FAIL b2b_pops: actual %0d required 2", pop_cnt - p0);
    else passes++;
  endtask

  task automatic test_wr_single;
    int c0 = compl_cnt;
    push(mk(2'd3, 5'd6, 2'd1, {23'd0, 32'h1000_0000}));
    expect_mwr(32'h1000_0000, 10'd16, "wr6");
    repeat (3) @(negedge clk);
    checks++;
    if (compl_cnt - c0 != 1 || last_id !== 2'd1) $display("[TB] FAIL wr6_compl: actual pulses=%0d id=%0d required 1/1", compl_cnt - c0, last_id);
    else passes++;
    checks++;
    if (busy !== 1'b0 || mwr_req !== 1'b0) $display("[TB] FAIL wr6_idle: actual busy=%b req=%b required 0/0", busy, mwr_req);
    else passes++;
  endtask

  task automatic test_wr_multi;
    int c0 = compl_cnt;
    push(mk(2'd3, 5'd9, 2'd2, {23'd0, 32'h0000_0F80}));
    expect_mwr(32'h0000_0F80, 10'd32, "wr9_t0");
    expect_mwr(32'h0000_1000, 10'd32, "wr9_t1");
    expect_mwr(32'h0000_1080, 10'd32, "wr9_t2");
    checks++;
    if (compl_cnt != c0) $display("[TB] FAIL wr9_early_compl: actual %0d required 0", compl_cnt - c0);
    else passes++;
    expect_mwr(32'h0000_1100, 10'd32, "wr9_t3");
    repeat (3) @(negedge clk);
    checks++;
    if (compl_cnt - c0 != 1 || last_id !== 2'd2) $display("[TB] FAIL wr9_compl: actual pulses=%0d id=%0d required 1/2", compl_cnt - c0, last_id);
    else passes++;
  endtask

  task automatic test_invalid_and_len0;
    int i0 = invalid_cnt, r0 = cplreq_cnt + mwrreq_cnt, c0;
    push(mk(2'd0, 5'd7, 2'd3, 55'h7F_FFFF_FFFF_FFFF));
    repeat (6) @(negedge clk);
    checks++;
    if (invalid_cnt - i0 != 1) $display("[TB] FAIL invalid_pulse: actual %0d required 1", invalid_cnt - i0);
    else passes++;
    checks++;
    if (cplreq_cnt + mwrreq_cnt != r0 || busy !== 1'b0) $display("[TB] FAIL invalid_noreq: actual req_cycles=%0d busy=%b required 0/0", cplreq_cnt + mwrreq_cnt - r0, busy);
    else passes++;
    c0 = compl_cnt;
    push(mk(2'd3, 5'd0, 2'd3, {23'd0, 32'h2000_0003}));
    expect_mwr(32'h2000_0000, 10'd1, "len0");
    repeat (3) @(negedge clk);
    checks++;
    if (compl_cnt - c0 != 1 || last_id !== 2'd3) $display("[TB] FAIL len0_compl: actual pulses=%0d id=%0d required 1/3", compl_cnt - c0, last_id);
    else passes++;
  endtask

  task automatic test_reset_mid;
    logic [54:0] pl = 55'h01_1111_2222_3333;
    int c0 = compl_cnt;
    bit ok = 1'b0;
    push(mk(2'd3, 5'd12, 2'd0, {23'd0, 32'h0000_0000}));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mwr_req) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) $display("[TB] FAIL rst_mid_timeout: actual no mwr_req, required request");
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mwr_req !== 1'b0 || busy !== 1'b0 || mwr_addr !== 32'd0 || mwr_len_dw !== 10'd0) $display("[TB] FAIL rst_mid_outputs: actual req=%b busy=%b addr=%h len=%0d required zeros", mwr_req, busy, mwr_addr, mwr_len_dw);
    else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (compl_cnt != c0) $display("[TB] FAIL rst_mid_compl: actual %0d required 0", compl_cnt - c0);
    else passes++;
    push(mk(2'd2, 5'd0, 2'd0, pl));
    wait_cpl(ok);
    checks++;
    if (cpl_with_data !== 1'b1 || cpl_info !== pl) $display("[TB] FAIL rst_mid_next: actual wd=%b info=%h required 1/%h", cpl_with_data, cpl_info, pl);
    else passes++;
    pulse_cpl_ack;
  endtask

  initial begin
    test_reset;
    test_cpl;
    test_back_to_back;
    test_wr_single;
    test_wr_multi;
    test_invalid_and_len0;
    test_reset_mid;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/us_cmd_dispatcher.md
# us_cmd_dispatcher

Consumer of the upstream command FIFO. Pops 128-bit entries written by the inbound FSM and turns them into TX-engine requests: completions (CPL/CPLD) for host reads of the register window, and posted memory-write bursts (WR32) for host-triggered DMA. When a DMA command finishes, it reports `up_wr_cmd_compl_o`/`cmd_id_o` back to the inbound FSM so the per-channel busy bit clears.

## Interface
- `MAX_PAYLOAD_BYTES`, 128: largest MWr payload per TLP; power of two, 4..512.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `us_cmd_fifo_empty_i`  in  1  FIFO empty.
- `us_cmd_fifo_dout_i`  in  128  FIFO read data, valid the cycle after `us_cmd_fifo_rd_en_o` (standard, non-FWFT).
- `us_cmd_fifo_rd_en_o`  out  1  pop strobe.
- `cpl_req_o`  out  1  completion request, held until ack.
- `cpl_with_data_o`  out  1  1: CplD, 0: Cpl.
- `cpl_info_o`  out  55  {tc[54:52], td[51], ep[50], attr[49:48], len[47:38], rid[37:22], tag[21:14], be[13:6], addr[5:0]}, copied from entry.
- `cpl_ack_i`  in  1  one-cycle pulse: completion sent.
- `mwr_req_o`  out  1  MWr32 TLP request, held until ack.
- `mwr_addr_o`  out  32  TLP byte address, [1:0] = 0.
- `mwr_len_dw_o`  out  10  TLP payload length in DW (1..MAX_PAYLOAD_BYTES/4).
- `mwr_ack_i`  in  1  one-cycle pulse: TLP sent.
- `up_wr_cmd_compl_o`  out  1  one-cycle pulse: DMA command finished.
- `cmd_id_o`  out  2  channel of finished command, valid with pulse.
- `invalid_cmd_o`  out  1  one-cycle pulse: entry dropped (type INVALID).
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- Entry decode: [127:64] ignored; type = [63:62] (`US_CMD_INVALID`=0, `US_CMD_CPL_TYPE`=1, `US_CMD_CPLD_TYPE`=2, `US_CMD_WR32_TYPE`=3); len = [61:57]; cmd_id = [56:55]; payload = [54:0]. WR32 host address = [31:0].
- States: IDLE, LOAD, CPL, WR_CALC, WR_REQ, DONE.
- IDLE: if `!us_cmd_fifo_empty_i`, assert `us_cmd_fifo_rd_en_o` one cycle, go LOAD. Never pops outside IDLE.
- LOAD: register entry. Type 1/2 -> CPL; type 3 -> WR_CALC; type 0 -> pulse `invalid_cmd_o`, IDLE.
- CPL: `cpl_req_o`=1, `cpl_with_data_o`=(type==2), `cpl_info_o`=payload; on `cpl_ack_i` -> IDLE. No `up_wr_cmd_compl_o` for completions.
- WR32 size: total bytes = 2^len, len clamped to 2..12 (len<2 -> 4 B, len>12 -> 4096 B). Remaining count 13 bits. Address forced DW-aligned (addr & ~3).
- WR_CALC: chunk = min(remaining, MAX_PAYLOAD_BYTES, 4096 − addr[11:0]); latch `mwr_addr_o`=cur addr, `mwr_len_dw_o`=chunk/4; go WR_REQ.
- WR_REQ: `mwr_req_o`=1, outputs stable; on `mwr_ack_i`: addr += chunk, remaining −= chunk; remaining==0 -> DONE else WR_CALC.
- DONE: pulse `up_wr_cmd_compl_o` with `cmd_id_o`=entry cmd_id; -> IDLE.
- Ack inputs outside their matching request state are ignored.
- Address wrap past 0xFFFF_FFFF: 32-bit wrap, no error.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0. Reset mid-command discards the in-flight entry; no completion pulse emitted.
- Pop at cycle N, LOAD at N+1, request asserted at N+2 (CPL or WR_REQ via WR_CALC at N+2, request N+3).
- Ack at cycle M: CPL -> IDLE at M+1, next pop earliest M+1. WR: next WR_CALC at M+1, next request M+2; last ack -> DONE pulse at M+1, IDLE at M+2.
- Request held continuously (no deassert) until ack; ack in same cycle as request's first assertion is accepted.
- Back-to-back entries: minimum 3 cycles per CPL entry with zero-latency ack.

## Test plan
- CPL: push type 1, payload with tag=0x5A, rid=0x0100 -> one `cpl_req_o`, `cpl_with_data_o`=0, `cpl_info_o`[21:14]=0x5A; ack -> idle, no compl pulse.
- CPLD then CPL back-to-back in FIFO -> two requests in order, `cpl_with_data_o` 1 then 0, one pop each.
- WR32 len=6, addr 0x1000_0000, MAX 128 -> single MWr len_dw=16; then `up_wr_cmd_compl_o` pulse with cmd_id=1.
- WR32 len=9 (512 B), addr 0x0000_0F80 -> TLPs: 0xF80/32 DW, 0x1000/32 DW, 0x1080/32 DW, 0x1100/32 DW; one compl pulse after 4th ack.
- Type 0 entry -> `invalid_cmd_o` pulse, no requests; len=0 WR32 -> one 1-DW TLP.
- Assert `rst_n` low while in WR_REQ -> outputs 0 immediately, no compl pulse; after release, next entry popped normally.
